// File: rtl/jk_mod_counter.sv
// jk_mod_counter: synchronous modulo-MODULUS up/down counter built from a
// vector of JK cells. Each cycle a J/K excitation pair is derived per bit
// (00 hold, 01 reset, 10 set, 11 toggle) and one clocked block applies the
// JK truth table. tc is a combinational lookahead that lets stages cascade.
module jk_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_n,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  // Highest legal count, and the modulus widened by one bit so the
  // out-of-range test also works when MODULUS == 2**WIDTH.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] ALL_0   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ALL_1   = {WIDTH{1'b1}};

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_load_err;

  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic             w_wrap_nxt;
  logic             w_lerr_nxt;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_load_oor;

  // Next state of a single JK cell.
  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic nxt;
    case ({j, k})
      2'b00:   nxt = q;
      2'b01:   nxt = 1'b0;
      2'b10:   nxt = 1'b1;
      2'b11:   nxt = ~q;
      default: nxt = q;
    endcase
    return nxt;
  endfunction

  assign w_at_max   = (r_q == MAX_VAL);
  assign w_at_zero  = (r_q == ALL_0);
  assign w_load_oor = ({1'b0, load_val} >= MOD_EXT);

  // Derive the per-bit J/K excitation and the pulse flags for this edge.
  always_comb begin
    logic w_run;
    w_j        = ALL_0;
    w_k        = ALL_0;
    w_wrap_nxt = 1'b0;
    w_lerr_nxt = 1'b0;
    w_run      = 1'b1;
    if (clr) begin
      // Reset code on every bit.
      w_k = ALL_1;
    end else if (load) begin
      if (w_load_oor) begin
        // Saturate an illegal load to the top of the range.
        w_j        = MAX_VAL;
        w_k        = ~MAX_VAL;
        w_lerr_nxt = 1'b1;
      end else begin
        w_j = load_val;
        w_k = ~load_val;
      end
    end else if (en) begin
      if (up_dn) begin
        if (w_at_max) begin
          w_k        = ALL_1;
          w_wrap_nxt = 1'b1;
        end else begin
          // Bit i toggles when all lower bits are one.
          for (int i = 0; i < WIDTH; i++) begin
            w_j[i] = w_run;
            w_k[i] = w_run;
            w_run  = w_run & r_q[i];
          end
        end
      end else begin
        if (w_at_zero) begin
          w_j        = MAX_VAL;
          w_k        = ~MAX_VAL;
          w_wrap_nxt = 1'b1;
        end else begin
          // Bit i toggles when all lower bits are zero.
          for (int i = 0; i < WIDTH; i++) begin
            w_j[i] = w_run;
            w_k[i] = w_run;
            w_run  = w_run & ~r_q[i];
          end
        end
      end
    end else begin
      // Hold: all excitation stays 00.
      w_j = ALL_0;
      w_k = ALL_0;
    end
  end

  // Apply the JK truth table per bit and register the one-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q        <= ALL_0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        r_q[i] <= jk_next(r_q[i], w_j[i], w_k[i]);
      end
      r_wrap     <= w_wrap_nxt;
      r_load_err <= w_lerr_nxt;
    end
  end

  assign count    = r_q;
  assign count_n  = ~r_q;
  assign wrap     = r_wrap;
  assign load_err = r_load_err;
  assign tc       = en & ~clr & ~load & (up_dn ? w_at_max : w_at_zero);

endmodule

// File: tb/tb_jk_mod_counter.sv
// Bench for jk_mod_counter: a modulo-10 stage, a modulo-16 stage sharing its
// inputs, and a second modulo-10 stage cascaded on the first stage's tc.
module tb_jk_mod_counter;

  logic       clk = 1'b0;
  logic       rst_n, en, up_dn, clr, load, hi_clr;
  logic [3:0] load_val;
  logic [3:0] count, count_n, cnt16, cnt16_n, cnt_hi, cnt_hi_n;
  logic       tc, wrap, load_err, tc16, wrap16, lerr16, tc_hi, wrap_hi, lerr_hi;

  int n_tests = 0;
  int n_fail  = 0;
  int m_lo    = 0;
  int m_full  = 0;
  bit e_wrap, e_lerr, e_wrap16, e_lerr16;

  always #5 clk = ~clk;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .count(count), .count_n(count_n), .tc(tc),
    .wrap(wrap), .load_err(load_err));

  jk_mod_counter #(.WIDTH(4), .MODULUS(16)) u_full (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt16), .count_n(cnt16_n), .tc(tc16),
    .wrap(wrap16), .load_err(lerr16));

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
    .clk(clk), .rst_n(rst_n), .en(tc), .up_dn(1'b1), .clr(hi_clr), .load(1'b0),
    .load_val(4'd0), .count(cnt_hi), .count_n(cnt_hi_n), .tc(tc_hi),
    .wrap(wrap_hi), .load_err(lerr_hi));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour from the counting rules, in plain integer arithmetic.
  task automatic model_step(input int md, input bit c, l, e, u, input int lv,
                            inout int cnt, output bit w, output bit le);
    w  = 1'b0;
    le = 1'b0;
    if (c) cnt = 0;
    else if (l) begin
      if (lv < md) cnt = lv;
      else begin
        cnt = md - 1;
        le  = 1'b1;
      end
    end else if (e) begin
      if (u) begin
        w   = (cnt == md - 1);
        cnt = (cnt + 1) % md;
      end else begin
        w   = (cnt == 0);
        cnt = (cnt + md - 1) % md;
      end
    end
  endtask

  // Drive one cycle of inputs, check tc, clock once, check registered state.
  task automatic apply(input bit c, l, e, u, input logic [3:0] lv);
    clr = c; load = l; en = e; up_dn = u; load_val = lv;
    #1;
    chk("tc", 32'(tc), 32'(e && !c && !l && (u ? (m_lo == 9) : (m_lo == 0))));
    chk("tc16", 32'(tc16), 32'(e && !c && !l && (u ? (m_full == 15) : (m_full == 0))));
    model_step(10, c, l, e, u, int'(lv), m_lo, e_wrap, e_lerr);
    model_step(16, c, l, e, u, int'(lv), m_full, e_wrap16, e_lerr16);
    @(posedge clk);
    #1;
    chk("count", 32'(count), m_lo);
    chk("count_n", 32'(count_n), 15 - m_lo);
    chk("wrap", 32'(wrap), 32'(e_wrap));
    chk("load_err", 32'(load_err), 32'(e_lerr));
    chk("count16", 32'(cnt16), m_full);
    chk("wrap16", 32'(wrap16), 32'(e_wrap16));
    chk("load_err16", 32'(lerr16), 32'(e_lerr16));
  endtask

  typedef struct {
    bit c, l, e, u;
    logic [3:0] lv;
    logic [3:0] exp_cnt;
    bit exp_wrap, exp_lerr;
  } vec_t;

  vec_t vecs[17];

  initial begin
    int wraps;
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd0,  4'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd6,  4'd6, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 4'd9, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  4'd9, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd5,  4'd5, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd13, 4'd0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd5,  4'd5, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd7,  4'd0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd3,  4'd3, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd4, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd3, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd15, 4'd9, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd0, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  4'd0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd9, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd10, 4'd9, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd9,  4'd9, 1'b0, 1'b0};

    rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0;
    load_val = 4'd0; hi_clr = 1'b0;
    #12;
    chk("rst_count", 32'(count), 0);
    chk("rst_count_n", 32'(count_n), 15);
    chk("rst_wrap", 32'(wrap), 0);
    chk("rst_load_err", 32'(load_err), 0);
    rst_n = 1'b1;

    // T1: asynchronous reset in the middle of a run.
    apply(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    for (int k = 0; k < 7; k++) apply(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    chk("t1_pre", 32'(count), 7);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t1_count", 32'(count), 0);
    chk("t1_count_n", 32'(count_n), 15);
    chk("t1_wrap", 32'(wrap), 0);
    chk("t1_load_err", 32'(load_err), 0);
    chk("t1_count16", 32'(cnt16), 0);
    m_lo = 0; m_full = 0;
    #2;
    rst_n = 1'b1;

    // T2: up count through the wrap.
    apply(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    for (int k = 1; k <= 12; k++) begin
      apply(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
      chk("t2_count", 32'(count), k % 10);
      chk("t2_wrap", 32'(wrap), 32'(k == 10));
    end

    // T3: down count through the wrap.
    apply(1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
    for (int k = 1; k <= 4; k++) begin
      apply(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      chk("t3_count", 32'(count), (12 - k) % 10);
      chk("t3_wrap", 32'(wrap), 32'(k == 3));
    end

    // T4/T5: loads, range saturation and priority from the vector table.
    for (int i = 0; i < 17; i++) begin
      apply(vecs[i].c, vecs[i].l, vecs[i].e, vecs[i].u, vecs[i].lv);
      chk("vec_count", 32'(count), 32'(vecs[i].exp_cnt));
      chk("vec_wrap", 32'(wrap), 32'(vecs[i].exp_wrap));
      chk("vec_load_err", 32'(load_err), 32'(vecs[i].exp_lerr));
    end

    // T6: two cascaded decades count 00..99 and back to 00.
    hi_clr = 1'b1;
    apply(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    hi_clr = 1'b0;
    wraps = 0;
    for (int k = 1; k <= 100; k++) begin
      apply(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
      chk("t6_lo", 32'(count), k % 10);
      chk("t6_hi", 32'(cnt_hi), (k / 10) % 10);
      if (wrap_hi === 1'b1) wraps++;
    end
    chk("t6_hi_wraps", wraps, 1);

    // Randomised mix checked against the reference model.
    for (int k = 0; k < 400; k++) begin
      apply(($urandom % 16) == 0, ($urandom % 6) == 0, ($urandom % 4) != 0,
            1'($urandom), 4'($urandom));
      chk("rand_range", 32'(count < 4'd10), 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
